counter_seek_arbiter: RTL and testbench
=======================================

COUNTER_SEEK_ARBITER -- requirements
Module: counter_seek_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0 / req1  input  1 each  seek request from requester 0 / 1; held high until grant.
REQ-005 SHALL have ports tgt0 / tgt1  input  W each  target count for requester 0 / 1; sampled at grant.
REQ-006 SHALL have port cnt_val  input  W  current value of the shared up/down counter.
REQ-007 SHALL have port cnt_en  output  1  counter step enable; counter steps once per cycle while high.
REQ-008 SHALL have port cnt_up  output  1  direction to counter: 1 = up, 0 = down.
REQ-009 SHALL have ports gnt0 / gnt1  output  1 each  one-cycle grant pulse to requester 0 / 1.
REQ-010 SHALL have port busy  output  1  high in SEEK and DONE states.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the granted seek completes.
REQ-012 SHALL have port done_id  output  1  requester served; valid while done is high.
REQ-013 SHALL have port err  output  1  one-cycle pulse on seek timeout (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, SEEK, DONE.
REQ-015 IDLE: if req0 or req1 high, SHALL latch the winner's target and id, compute direction, and enter SEEK on the next edge; gnt of the winner SHALL be high for exactly the first SEEK cycle.
REQ-016 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset requester 0 has priority.
REQ-017 Direction SHALL be latched at grant as shortest modulo-2^W path: d_up = (tgt - cnt_val) mod 2^W, d_dn = (cnt_val - tgt) mod 2^W; cnt_up = 1 if d_up <= d_dn (tie goes up).
REQ-018 SEEK: cnt_en SHALL be combinational: high iff cnt_val != latched target; cnt_up SHALL equal the latched direction.
REQ-019 SEEK: when cnt_val == latched target, SHALL enter DONE on the next edge with cnt_en low in that cycle.
REQ-020 Target equal to cnt_val at grant SHALL give one SEEK cycle with cnt_en low, then DONE; no counter step.
REQ-021 Wrap-around SHALL rely on the counter wrapping (15->0 up, 0->15 down for W=4); the controller SHALL NOT special-case it.
REQ-022 DONE: done = 1 and done_id = served id for one cycle; SHALL return to IDLE next edge; requests are not evaluated in DONE.
REQ-023 Seek latency SHALL be 2 + min(d_up, d_dn) cycles from the grant edge to the done pulse inclusive.
REQ-024 Outside SEEK, cnt_en SHALL be 0; requests arriving during SEEK/DONE SHALL wait, not be dropped.

Reset
REQ-025 reset high at any edge, including mid-SEEK, SHALL force IDLE, round-robin pointer to favour requester 0, and cnt_en, cnt_up, gnt0, gnt1, busy, done, done_id, err = 0; no done SHALL be issued for an aborted seek.

Configuration
REQ-026 Macro SEEK_TIMEOUT_EN SHALL select timeout logic.
REQ-027 With SEEK_TIMEOUT_EN defined: a cycle counter SHALL count SEEK cycles; if 2^W + 1 SEEK cycles elapse without match, SHALL pulse err for one cycle, drive cnt_en low, and return to IDLE without done.
REQ-028 Without SEEK_TIMEOUT_EN: no timeout counter SHALL exist, err SHALL be tied 0, and SEEK lasts until match.

Verification
REQ-029 Reset, cnt_val=3, req0=1 tgt0=7 -> gnt0 next cycle, cnt_up=1, cnt_en high 4 cycles, done with done_id=0 at cycle 6 after grant edge.
REQ-030 cnt_val=1, req1=1 tgt1=14 -> cnt_up=0, counter passes 0 and wraps to 15, then 14; 3 enable cycles, done_id=1.
REQ-031 req0 and req1 high together from reset -> gnt0 first; second simultaneous pair after that -> gnt1 first.
REQ-032 cnt_val=9, req0 tgt0=9 -> gnt0, cnt_en never high, done 2 cycles after grant edge.
REQ-033 reset asserted during SEEK with cnt_val=5, tgt=12 -> next cycle IDLE, cnt_en=0, busy=0, no done pulse.
REQ-034 With SEEK_TIMEOUT_EN, counter model held stuck at 2, tgt=6 -> err pulse after 17 SEEK cycles, no done; without macro, err stays 0.

Source files
------------

// File: rtl/counter_seek_arbiter.sv
// Round-robin seek controller steering a shared up/down counter to a target.
// Define SEEK_TIMEOUT_EN to abort seeks that never reach their target.
module counter_seek_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] tgt0,
  input  logic [W-1:0] tgt1,
  input  logic [W-1:0] cnt_val,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] tgt_q;
  logic         id_q;
  logic         up_q;
  logic         first_q;
  logic         last_q;

  logic         grant;
  logic         pick;
  logic [W-1:0] tgt_pick;
  logic [W-1:0] d_up;
  logic [W-1:0] d_dn;
  logic         match;
  logic         tmo;

  always_comb begin
    grant    = (state == IDLE) && (req0 || req1);
    pick     = (req0 && req1) ? ~last_q : req1;
    tgt_pick = pick ? tgt1 : tgt0;
    d_up     = tgt_pick - cnt_val;
    d_dn     = cnt_val - tgt_pick;
    match    = (cnt_val == tgt_q);
  end

`ifdef SEEK_TIMEOUT_EN
  localparam logic [W:0] TMO_LAST = {1'b1, {W{1'b0}}};

  logic [W:0] tmo_q;

  // Index of the current SEEK cycle; the 2^W+1-th one without a match aborts.
  always_ff @(posedge clk) begin
    if (reset || state != SEEK)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 1'b1;
  end

  assign tmo = (state == SEEK) && (tmo_q == TMO_LAST) && !match;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tgt_q   <= '0;
      id_q    <= 1'b0;
      up_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      first_q <= grant;
      if (grant) begin
        tgt_q  <= tgt_pick;
        id_q   <= pick;
        up_q   <= (d_up <= d_dn);
        last_q <= pick;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_up    = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    done_id   = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant)
          state_nxt = SEEK;
      end
      SEEK: begin
        busy   = 1'b1;
        cnt_up = up_q;
        cnt_en = !match && !tmo;
        err    = tmo;
        gnt0   = first_q && !id_q;
        gnt1   = first_q && id_q;
        if (match)
          state_nxt = DONE;
        else if (tmo)
          state_nxt = IDLE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        done_id   = id_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_seek_arbiter.sv
// Directed bench for counter_seek_arbiter with a behavioural wrapping counter.
// Define SEEK_TIMEOUT_EN to exercise the timeout path.
module tb_counter_seek_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [3:0] tgt0, tgt1;
  logic [3:0] cnt_val;
  logic       cnt_en, cnt_up;
  logic       gnt0, gnt1, busy, done, done_id, err;

  logic       load;
  logic [3:0] load_val;
  logic       stuck;

  int tests = 0;
  int fails = 0;

  counter_seek_arbiter #(.W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .tgt0(tgt0), .tgt1(tgt1),
    .cnt_val(cnt_val),
    .cnt_en(cnt_en), .cnt_up(cnt_up),
    .gnt0(gnt0), .gnt1(gnt1),
    .busy(busy), .done(done),
    .done_id(done_id), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load)
      cnt_val <= load_val;
    else if (cnt_en && !stuck)
      cnt_val <= cnt_up ? cnt_val + 4'd1 : cnt_val - 4'd1;
  end

  typedef struct {
    logic [3:0] cnt0;
    bit         r0, r1;
    logic [3:0] t0, t1;
    bit         eg0, eg1, eup;
    int         een, elat;
    bit         eid;
  } vec_t;

  vec_t v[7];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_cnt(input logic [3:0] val);
    @(negedge clk);
    load = 1'b1;
    load_val = val;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the grant sample; counts samples up to and including done.
  task automatic wait_done(output bit ok, output int lat,
                           output int ens, output int id);
    ok = 1'b0; lat = 0; ens = 0; id = 0;
    for (int k = 0; k < 40; k++) begin
      lat++;
      ens += int'(cnt_en);
      if (done) begin
        ok = 1'b1;
        id = int'(done_id);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_reqs();
    req0 = 1'b0; req1 = 1'b0; tgt0 = '0; tgt1 = '0;
  endtask

  initial begin
    bit ok;
    int lat, ens, id, g0, g1, up, n, dn, er;
    logic [3:0] tw;

    v[0] = '{4'd3,  1, 0, 4'd7,  4'd0,  1, 0, 1, 4, 6,  0};
    v[1] = '{4'd1,  0, 1, 4'd0,  4'd14, 0, 1, 0, 3, 5,  1};
    v[2] = '{4'd9,  1, 0, 4'd9,  4'd0,  1, 0, 1, 0, 2,  0};
    v[3] = '{4'd0,  1, 1, 4'd8,  4'd2,  0, 1, 1, 2, 4,  1};
    v[4] = '{4'd2,  1, 1, 4'd10, 4'd5,  1, 0, 1, 8, 10, 0};
    v[5] = '{4'd14, 1, 0, 4'd1,  4'd0,  1, 0, 1, 3, 5,  0};
    v[6] = '{4'd0,  0, 1, 4'd0,  4'd15, 0, 1, 0, 1, 3,  1};

    reset = 1'b1; load = 1'b0; load_val = '0; stuck = 1'b0;
    idle_reqs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_outs", {cnt_up, gnt0, gnt1, done, done_id, err}, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_cnt(v[i].cnt0);
      req0 = v[i].r0; req1 = v[i].r1;
      tgt0 = v[i].t0; tgt1 = v[i].t1;
      wait_gnt(ok);
      chk($sformatf("v%0d_gnt_seen", i), ok, 1);
      g0 = gnt0; g1 = gnt1; up = cnt_up;
      idle_reqs();
      chk($sformatf("v%0d_gnt0", i), g0, v[i].eg0);
      chk($sformatf("v%0d_gnt1", i), g1, v[i].eg1);
      chk($sformatf("v%0d_up", i), up, v[i].eup);
      wait_done(ok, lat, ens, id);
      chk($sformatf("v%0d_done_seen", i), ok, 1);
      chk($sformatf("v%0d_en_cycles", i), ens, v[i].een);
      chk($sformatf("v%0d_latency", i), lat, v[i].elat);
      chk($sformatf("v%0d_done_id", i), id, v[i].eid);
      tw = v[i].eid ? v[i].t1 : v[i].t0;
      chk($sformatf("v%0d_cnt_final", i), cnt_val, tw);
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Fresh reset: pair goes to 0, held req1 waits and is then served.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load_cnt(4'd4);
    req0 = 1'b1; req1 = 1'b1; tgt0 = 4'd4; tgt1 = 4'd6;
    wait_gnt(ok);
    chk("rr_first_gnt0", gnt0, 1);
    chk("rr_first_gnt1", gnt1, 0);
    req0 = 1'b0;
    wait_done(ok, lat, ens, id);
    chk("rr_first_id", id, 0);
    wait_gnt(ok);
    chk("rr_wait_gnt1", ok && gnt1, 1);
    req1 = 1'b0;
    wait_done(ok, lat, ens, id);
    chk("rr_wait_id", id, 1);
    chk("rr_wait_lat", lat, 4);
    idle_reqs();

    // Reset mid-seek aborts without a done pulse.
    load_cnt(4'd5);
    req0 = 1'b1; tgt0 = 4'd12;
    wait_gnt(ok);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_en", cnt_en, 0);
    chk("abort_outs", {cnt_up, gnt0, gnt1, done, done_id, err}, 0);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      dn += int'(done) + int'(busy);
    end
    chk("abort_no_done", dn, 0);

    // Counter held stuck so the seek can never match.
    stuck = 1'b1;
    load_cnt(4'd2);
    req0 = 1'b1; tgt0 = 4'd6;
    wait_gnt(ok);
    req0 = 1'b0;
`ifdef SEEK_TIMEOUT_EN
    n = 0; dn = 0; er = 0;
    for (int k = 0; k < 40; k++) begin
      n++;
      dn += int'(done);
      if (err) begin
        er = 1;
        chk("tmo_en_low", cnt_en, 0);
        break;
      end
      @(negedge clk);
    end
    chk("tmo_err_seen", er, 1);
    chk("tmo_seek_cycles", n, 17);
    @(negedge clk);
    chk("tmo_err_pulse", err, 0);
    chk("tmo_idle", busy, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("tmo_no_done", dn, 0);
    stuck = 1'b0;
`else
    er = 0;
    for (int k = 0; k < 30; k++) begin
      er += int'(err);
      @(negedge clk);
    end
    chk("notmo_err", er, 0);
    chk("notmo_busy", busy, 1);
    stuck = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("notmo_done", ok, 1);
    chk("notmo_cnt", cnt_val, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
